mipi_pll_supervisor: RTL and testbench

// - Drives the MIPI PLL reset and consumes its lock indication; the counterpart of the PLL wrapper.
// - Runs in the 50 MHz reference domain: pulses PLL reset, waits for lock with timeout/retry, and qualifies lock stability.
// - Releases downstream MIPI logic (20/25 MHz consumers) via clk_ready/user_rst only after lock is stable.
// - Restarts the PLL on loss of lock.

---
 rtl/mipi_pll_pkg.sv | 20 ++
 rtl/mipi_bit_sync.sv | 23 ++
 rtl/mipi_pll_supervisor.sv | 133 +++++++++++++
 tb/tb_mipi_pll_supervisor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_pll_pkg.sv
// Shared types and constants for the MIPI PLL supervisor.
package mipi_pll_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_sup_state_t;

  localparam int unsigned LOSS_CNT_W = 16;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mipi_bit_sync.sv
// Multi-flop single-bit synchronizer, asynchronously reset to 0.
module mipi_bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mipi_pll_supervisor.sv
// MIPI PLL reset/lock supervisor in the 50 MHz reference domain.
// Optional lock-loss counter enabled by defining MIPI_PLL_LOSS_CNT_EN.
module mipi_pll_supervisor
  import mipi_pll_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned STABLE_CYC       = 1024,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                           refclk,
  input  logic                           rst,
  input  logic                           pll_locked,
  input  logic                           retry_req,
  output logic                           pll_rst,
  output logic                           clk_ready,
  output logic                           user_rst,
  output logic                           pll_fail,
  output logic                           lock_lost,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`ifdef MIPI_PLL_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0]          loss_cnt
`endif
);

  localparam int unsigned CNT_MAX = max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  pll_sup_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lost_d;
  logic               locked_s;

  mipi_bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    lost_d  = 1'b0;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_cnt + 1'b1;
          state_d = (retry_d == RETRY_LIMIT) ? FAIL : PLL_RST;
        end
      end
      STABLE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_d = PLL_RST;
          retry_d = '0;
          lost_d  = 1'b1;
        end
      end
      FAIL: begin
        if (retry_req) begin
          state_d = PLL_RST;
          retry_d = '0;
        end
      end
      default: state_d = PLL_RST;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == PLL_RST || state_q == WAIT_LOCK || state_q == STABLE) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      pll_rst   <= 1'b1;
      clk_ready <= 1'b0;
      user_rst  <= 1'b1;
      pll_fail  <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst   <= (state_d == PLL_RST) || (state_d == FAIL);
      clk_ready <= (state_d == RUN);
      user_rst  <= (state_d != RUN);
      pll_fail  <= (state_d == FAIL);
      lock_lost <= lost_d;
      retry_cnt <= retry_d;
    end
  end

`ifdef MIPI_PLL_LOSS_CNT_EN
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (lost_d && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end
`else
  // No loss counter: lock_lost is the only loss indication.
`endif

endmodule

// File: tb/tb_mipi_pll_supervisor.sv
// Directed, table-driven bench for mipi_pll_supervisor with small test parameters.
module tb_mipi_pll_supervisor;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       retry_req;
  logic       pll_rst, clk_ready, user_rst, pll_fail, lock_lost;
  logic [1:0] retry_cnt;
`ifdef MIPI_PLL_LOSS_CNT_EN
  logic [15:0] loss_cnt;
`endif

  int tests = 0;
  int fails = 0;

  mipi_pll_supervisor #(
    .RST_PULSE_CYC   (4),
    .LOCK_TIMEOUT_CYC(32),
    .STABLE_CYC      (8),
    .MAX_RETRY       (3),
    .SYNC_STAGES     (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .retry_req (retry_req),
    .pll_rst   (pll_rst),
    .clk_ready (clk_ready),
    .user_rst  (user_rst),
    .pll_fail  (pll_fail),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt)
`ifdef MIPI_PLL_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  always #10 refclk = ~refclk;

  // {pll_rst, clk_ready, user_rst, pll_fail, lock_lost, retry_cnt}
  typedef struct {
    logic       locked;
    logic       req;
    int         n;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic logic [6:0] outs();
    return {pll_rst, clk_ready, user_rst, pll_fail, lock_lost, retry_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic add(input logic l, input logic r, input int n, input logic [6:0] e,
                     input string name);
    vec_t v;
    v.locked = l;
    v.req    = r;
    v.n      = n;
    v.exp    = e;
    v.name   = name;
    vq.push_back(v);
  endtask

  // Edges until clk_ready rises, bounded.
  task automatic measure_ready(input string name, input int exp_edges);
    int n = 0;
    while (!clk_ready && n < 60) begin
      step();
      n++;
    end
    check(name, n, exp_edges);
  endtask

  // Edges until lock_lost pulses, bounded.
  task automatic measure_lost(input string name, input int exp_edges);
    int n = 0;
    while (!lock_lost && n < 20) begin
      step();
      n++;
    end
    check(name, n, exp_edges);
  endtask

  // Edges until pll_rst releases, bounded.
  task automatic measure_rst_low(input string name, input int exp_edges);
    int n = 0;
    while (pll_rst && n < 20) begin
      step();
      n++;
    end
    check(name, n, exp_edges);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    retry_req  = 1'b0;

    // Timeout/retry/FAIL walk with lock held low; all counts relative to rst release.
    add(0, 0, 3,  7'b1010000, "rst_pulse_hold");
    add(0, 0, 1,  7'b0010000, "rst_pulse_end");
    add(0, 1, 1,  7'b0010000, "req_ignored_wait");
    add(0, 0, 30, 7'b0010000, "wait_before_timeout");
    add(0, 0, 1,  7'b1010001, "timeout1");
    add(0, 0, 3,  7'b1010001, "rst2_hold");
    add(0, 0, 1,  7'b0010001, "rst2_end");
    add(0, 0, 32, 7'b1010010, "timeout2");
    add(0, 0, 4,  7'b0010010, "rst3_end");
    add(0, 0, 31, 7'b0010010, "wait3_last");
    add(0, 0, 1,  7'b1011011, "fail_enter");
    add(0, 0, 20, 7'b1011011, "fail_hold");
    add(0, 1, 1,  7'b1010000, "retry_req");
    add(0, 0, 3,  7'b1010000, "retry_rst_hold");
    add(0, 0, 1,  7'b0010000, "retry_rst_end");

    repeat (3) step();
    check("reset_outs", outs(), 7'b1010000);
`ifdef MIPI_PLL_LOSS_CNT_EN
    check("reset_loss_cnt", loss_cnt, 0);
`endif
    rst = 1'b0;

    foreach (vq[i]) begin
      pll_locked = vq[i].locked;
      retry_req  = vq[i].req;
      repeat (vq[i].n) step();
      retry_req = 1'b0;
      check(vq[i].name, outs(), vq[i].exp);
    end

    // Now in WAIT_LOCK: sync (2) + detect (1) + stable window (8).
    pll_locked = 1'b1;
    measure_ready("lock_to_ready", 11);
    check("run_outs", outs(), 7'b0100000);

    // Lock loss in RUN: seen after the sync chain, pulse on the FSM edge.
    pll_locked = 1'b0;
    measure_lost("lock_lost_latency", 3);
    check("lost_outs", outs(), 7'b1010100);
`ifdef MIPI_PLL_LOSS_CNT_EN
    check("loss_cnt_1", loss_cnt, 1);
`endif
    step();
    check("lost_one_cycle", lock_lost, 0);
    measure_rst_low("restart_pulse", 3);

    // Glitch in STABLE at cnt=5: lock seen at edge 3, cnt=5 after edge 8.
    pll_locked = 1'b1;
    repeat (8) step();
    pll_locked = 1'b0;
    repeat (3) step();
    check("glitch_not_ready", clk_ready, 0);
    pll_locked = 1'b1;
    measure_ready("glitch_fresh_ready", 11);

    // Lock arriving exactly on the timeout cycle wins.
    pll_locked = 1'b0;
    measure_lost("lost2", 3);
    measure_rst_low("restart2", 4);
    repeat (29) step();
    pll_locked = 1'b1;
    repeat (3) step();
    check("tie_lock_wins", {pll_rst, retry_cnt}, 3'b000);
    measure_ready("tie_ready", 8);

    // One cycle later and the timeout wins; retry_cnt then clears on lock loss.
    pll_locked = 1'b0;
    measure_lost("lost3", 3);
`ifdef MIPI_PLL_LOSS_CNT_EN
    check("loss_cnt_3", loss_cnt, 3);
`endif
    measure_rst_low("restart3", 4);
    repeat (30) step();
    pll_locked = 1'b1;
    repeat (2) step();
    check("late_lock_timeout", {pll_rst, retry_cnt}, 3'b101);
    measure_ready("late_lock_ready", 13);
    pll_locked = 1'b0;
    measure_lost("lost4", 3);
    check("run_loss_clears_retry", retry_cnt, 0);

    // Async reset while in STABLE.
    measure_rst_low("restart4", 4);
    pll_locked = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("rst_in_stable", outs(), 7'b1010000);
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_hold", pll_rst, 1);
    step();
    check("post_rst_release", pll_rst, 0);
    measure_ready("post_rst_ready", 9);

    // Async reset in RUN drops clk_ready without an edge.
    rst = 1'b1;
    #1;
    check("rst_in_run", outs(), 7'b1010000);
`ifdef MIPI_PLL_LOSS_CNT_EN
    check("rst_loss_cnt", loss_cnt, 0);
`endif
    step();
    rst        = 1'b0;
    pll_locked = 1'b0;

    // Reach FAIL (3 x (4 + 32) edges), then reset there.
    begin
      int n = 0;
      while (!pll_fail && n < 200) begin
        step();
        n++;
      end
      check("reach_fail", n, 108);
    end
    rst = 1'b1;
    #1;
    check("rst_in_fail", outs(), 7'b1010000);
    step();
    rst = 1'b0;
    repeat (4) step();
    check("fail_rst_restart", outs(), 7'b0010000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
